// File: rtl/gpu_pkg.sv
// Shared definitions for the raster scan controller and its pixel coverage unit.
// Contents:
//   DEF_COORD_WIDTH / DEF_COLOR_WIDTH : default coordinate and color widths
//   bbox_t                            : inclusive unsigned bounding box
//   state_e                           : scan controller FSM states
package gpu_pkg;

  localparam int DEF_COORD_WIDTH = 16;
  localparam int DEF_COLOR_WIDTH = 16;

  typedef struct packed {
    logic [DEF_COORD_WIDTH-1:0] xmin;
    logic [DEF_COORD_WIDTH-1:0] xmax;
    logic [DEF_COORD_WIDTH-1:0] ymin;
    logic [DEF_COORD_WIDTH-1:0] ymax;
  } bbox_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ppu.sv
// Pixel coverage unit: evaluates three edge planes e = a*x + b*y + c at one
// pixel and reports the pixel covered when every plane is non-negative.
// Ports:
//   bounds    : [plane][coef] signed coefficients, coef 0=a, 1=b, 2=c
//   color_in  : flat triangle color
//   x, y      : unsigned pixel coordinates under test
//   valid     : pixel is covered by all three planes
//   color_out : color to attach to the fragment
module ppu
  import gpu_pkg::*;
#(
  parameter int COORD_WIDTH = DEF_COORD_WIDTH,
  parameter int COLOR_WIDTH = DEF_COLOR_WIDTH
) (
  input  logic [2:0][2:0][COORD_WIDTH-1:0] bounds,
  input  logic [COLOR_WIDTH-1:0]           color_in,
  input  logic [COORD_WIDTH-1:0]           x,
  input  logic [COORD_WIDTH-1:0]           y,
  output logic                             valid,
  output logic [COLOR_WIDTH-1:0]           color_out
);

  // Wide enough for a signed W x unsigned W product plus two more terms.
  localparam int EW = 2 * COORD_WIDTH + 3;

  function automatic logic signed [EW-1:0] sext(input logic [COORD_WIDTH-1:0] v);
    return {{(EW-COORD_WIDTH){v[COORD_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [EW-1:0] zext(input logic [COORD_WIDTH-1:0] v);
    return {{(EW-COORD_WIDTH){1'b0}}, v};
  endfunction

  logic signed [EW-1:0] xs_s;
  logic signed [EW-1:0] ys_s;
  logic signed [EW-1:0] edge_s [3];
  logic [2:0]           inside_s;

  assign xs_s = zext(x);
  assign ys_s = zext(y);

  for (genvar p = 0; p < 3; p++) begin : g_plane
    assign edge_s[p]   = sext(bounds[p][0]) * xs_s + sext(bounds[p][1]) * ys_s + sext(bounds[p][2]);
    assign inside_s[p] = ~edge_s[p][EW-1];
  end

  assign valid     = &inside_s;
  assign color_out = color_in;

endmodule

// File: rtl/raster_scan_ctrl.sv
// Raster scan controller: accepts a triangle job (bbox, edge planes, color),
// walks the bbox in raster order one pixel per advance, and streams covered
// pixels as fragments through a valid/ready handshake.
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   job_valid / job_ready       : job handshake (ready only in IDLE)
//   job_xmin..job_ymax          : inclusive unsigned bounding box
//   job_bounds                  : [plane][coef] signed edge coefficients {a,b,c}
//   job_color                   : flat triangle color
//   frag_valid / frag_ready     : fragment handshake
//   frag_x, frag_y, frag_color  : fragment payload
//   done                        : one-cycle pulse at end of a job
//   stat_tested, stat_emitted   : wrapping counters of evaluated / emitted pixels
module raster_scan_ctrl
  import gpu_pkg::*;
#(
  parameter int COORD_WIDTH = DEF_COORD_WIDTH,
  parameter int COLOR_WIDTH = DEF_COLOR_WIDTH
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [COORD_WIDTH-1:0]           job_xmin,
  input  logic [COORD_WIDTH-1:0]           job_xmax,
  input  logic [COORD_WIDTH-1:0]           job_ymin,
  input  logic [COORD_WIDTH-1:0]           job_ymax,
  input  logic [2:0][2:0][COORD_WIDTH-1:0] job_bounds,
  input  logic [COLOR_WIDTH-1:0]           job_color,
  output logic                             frag_valid,
  input  logic                             frag_ready,
  output logic [COORD_WIDTH-1:0]           frag_x,
  output logic [COORD_WIDTH-1:0]           frag_y,
  output logic [COLOR_WIDTH-1:0]           frag_color,
  output logic                             done,
  output logic [31:0]                      stat_tested,
  output logic [31:0]                      stat_emitted
);

  localparam logic [COORD_WIDTH-1:0] COORD_ONE = {{(COORD_WIDTH-1){1'b0}}, 1'b1};

  state_e                           state_r;
  state_e                           state_nxt_s;
  logic [COORD_WIDTH-1:0]           xmin_r;
  logic [COORD_WIDTH-1:0]           xmax_r;
  logic [COORD_WIDTH-1:0]           ymax_r;
  logic [2:0][2:0][COORD_WIDTH-1:0] bounds_r;
  logic [COLOR_WIDTH-1:0]           color_r;
  logic [COORD_WIDTH-1:0]           x_r;
  logic [COORD_WIDTH-1:0]           y_r;
  logic                             frag_valid_r;
  logic [COORD_WIDTH-1:0]           frag_x_r;
  logic [COORD_WIDTH-1:0]           frag_y_r;
  logic [COLOR_WIDTH-1:0]           frag_color_r;
  logic [31:0]                      tested_r;
  logic [31:0]                      emitted_r;
  logic                             job_ready_s;
  logic                             done_s;
  logic                             accept_s;
  logic                             box_ok_s;
  logic                             advance_s;
  logic                             row_end_s;
  logic                             last_s;
  logic                             cov_valid_s;
  logic [COLOR_WIDTH-1:0]           cov_color_s;

  assign accept_s  = job_valid && (state_r == ST_IDLE);
  assign box_ok_s  = (job_xmin <= job_xmax) && (job_ymin <= job_ymax);
  assign advance_s = (state_r == ST_SCAN) && (!frag_valid_r || frag_ready);
  // Equality compares keep a box touching the top of the coordinate range finite.
  assign row_end_s = (x_r == xmax_r);
  assign last_s    = row_end_s && (y_r == ymax_r);

  ppu #(
    .COORD_WIDTH (COORD_WIDTH),
    .COLOR_WIDTH (COLOR_WIDTH)
  ) u_ppu (
    .bounds    (bounds_r),
    .color_in  (color_r),
    .x         (x_r),
    .y         (y_r),
    .valid     (cov_valid_s),
    .color_out (cov_color_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; an empty box skips straight to DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (job_valid) begin
          state_nxt_s = box_ok_s ? ST_SCAN : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (advance_s && last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    job_ready_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: job_ready_s = 1'b1;
      ST_SCAN: job_ready_s = 1'b0;
      ST_DONE: done_s      = 1'b1;
      default: job_ready_s = 1'b0;
    endcase
  end

  assign job_ready = job_ready_s;
  assign done      = done_s;

  // Job latch on accept and raster-order scan position stepping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      xmin_r   <= {COORD_WIDTH{1'b0}};
      xmax_r   <= {COORD_WIDTH{1'b0}};
      ymax_r   <= {COORD_WIDTH{1'b0}};
      bounds_r <= {(9*COORD_WIDTH){1'b0}};
      color_r  <= {COLOR_WIDTH{1'b0}};
      x_r      <= {COORD_WIDTH{1'b0}};
      y_r      <= {COORD_WIDTH{1'b0}};
    end else if (accept_s) begin
      xmin_r   <= job_xmin;
      xmax_r   <= job_xmax;
      ymax_r   <= job_ymax;
      bounds_r <= job_bounds;
      color_r  <= job_color;
      x_r      <= job_xmin;
      y_r      <= job_ymin;
    end else if (advance_s && !last_s) begin
      if (row_end_s) begin
        x_r <= xmin_r;
        y_r <= y_r + COORD_ONE;
      end else begin
        x_r <= x_r + COORD_ONE;
      end
    end
  end

  // Fragment output register: load on a covered advance, drop once consumed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frag_valid_r <= 1'b0;
      frag_x_r     <= {COORD_WIDTH{1'b0}};
      frag_y_r     <= {COORD_WIDTH{1'b0}};
      frag_color_r <= {COLOR_WIDTH{1'b0}};
    end else if (advance_s && cov_valid_s) begin
      frag_valid_r <= 1'b1;
      frag_x_r     <= x_r;
      frag_y_r     <= y_r;
      frag_color_r <= cov_color_s;
    end else if (frag_ready) begin
      frag_valid_r <= 1'b0;
    end
  end

  assign frag_valid = frag_valid_r;
  assign frag_x     = frag_x_r;
  assign frag_y     = frag_y_r;
  assign frag_color = frag_color_r;

  // Statistics counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tested_r  <= 32'd0;
      emitted_r <= 32'd0;
    end else begin
      if (advance_s) begin
        tested_r <= tested_r + 32'd1;
      end
      if (frag_valid_r && frag_ready) begin
        emitted_r <= emitted_r + 32'd1;
      end
    end
  end

  assign stat_tested  = tested_r;
  assign stat_emitted = emitted_r;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
module tb_raster_scan_ctrl;
  import gpu_pkg::*;

  localparam int CW = 16;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    job_valid;
  logic                    job_ready;
  logic [CW-1:0]           job_xmin, job_xmax, job_ymin, job_ymax;
  logic [2:0][2:0][CW-1:0] job_bounds;
  logic [CW-1:0]           job_color;
  logic                    frag_valid;
  logic                    frag_ready;
  logic [CW-1:0]           frag_x, frag_y, frag_color;
  logic                    done;
  logic [31:0]             stat_tested, stat_emitted;

  always #5 clk = ~clk;

  raster_scan_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_xmin     (job_xmin),
    .job_xmax     (job_xmax),
    .job_ymin     (job_ymin),
    .job_ymax     (job_ymax),
    .job_bounds   (job_bounds),
    .job_color    (job_color),
    .frag_valid   (frag_valid),
    .frag_ready   (frag_ready),
    .frag_x       (frag_x),
    .frag_y       (frag_y),
    .frag_color   (frag_color),
    .done         (done),
    .stat_tested  (stat_tested),
    .stat_emitted (stat_emitted)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int x;
    int y;
    int color;
  } frag_t;

  frag_t  exp_q[$];
  longint model_tested  = 0;
  int     model_emitted = 0;
  int     done_cnt      = 0;

  int ex[6] = '{2, 3, 4, 2, 3, 4};
  int ey[6] = '{1, 1, 1, 2, 2, 2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Coverage straight from the edge-function definition, in 64-bit integers.
  function automatic bit model_cov(input int x, input int y, input logic [2:0][2:0][CW-1:0] b);
    longint e;
    for (int p = 0; p < 3; p++) begin
      e = longint'($signed(b[p][0])) * x + longint'($signed(b[p][1])) * y + longint'($signed(b[p][2]));
      if (e < 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bbox_t mk_box(input logic [CW-1:0] x0, input logic [CW-1:0] x1,
                                   input logic [CW-1:0] y0, input logic [CW-1:0] y1);
    bbox_t b;
    b.xmin = x0; b.xmax = x1; b.ymin = y0; b.ymax = y1;
    return b;
  endfunction

  // Enumerate the whole box: every pixel is tested, covered ones are queued.
  task automatic model_job(input bbox_t bx, input logic [2:0][2:0][CW-1:0] b, input logic [CW-1:0] col);
    frag_t f;
    if (bx.xmin <= bx.xmax && bx.ymin <= bx.ymax) begin
      for (int y = int'(bx.ymin); y <= int'(bx.ymax); y++) begin
        for (int x = int'(bx.xmin); x <= int'(bx.xmax); x++) begin
          model_tested++;
          if (model_cov(x, y, b)) begin
            f.x = x; f.y = y; f.color = int'(col);
            exp_q.push_back(f);
          end
        end
      end
    end
  endtask

  // Offer a job from posedge+1, return at posedge+1 after the accept edge.
  task automatic issue_job(input bbox_t bx, input logic [2:0][2:0][CW-1:0] b, input logic [CW-1:0] col);
    int n = 0;
    job_valid  = 1'b1;
    job_xmin   = bx.xmin; job_xmax = bx.xmax;
    job_ymin   = bx.ymin; job_ymax = bx.ymax;
    job_bounds = b;
    job_color  = col;
    while (job_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("job_accept_wait", 64'(n < 50), 64'd1);
    @(posedge clk);
    model_job(bx, b, col);
    #1;
    job_valid = 1'b0;
    job_xmin  = 16'($urandom); job_xmax = 16'($urandom);
    job_ymin  = 16'($urandom); job_ymax = 16'($urandom);
    job_color = 16'($urandom);
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 3; c++)
        job_bounds[p][c] = 16'($urandom);
  endtask

  // Model is cleared by the same reset edge that clears the DUT.
  always @(posedge clk) begin
    if (resetn === 1'b0) begin
      exp_q.delete();
      model_tested  = 0;
      model_emitted = 0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      check("stat_emitted", stat_emitted, 64'(model_emitted));
      if (frag_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frag: got (%0h,%0h) expected none", frag_x, frag_y);
        end else begin
          check("frag_x", frag_x, 64'(exp_q[0].x));
          check("frag_y", frag_y, 64'(exp_q[0].y));
          check("frag_color", frag_color, 64'(exp_q[0].color));
          if (frag_ready === 1'b1) begin
            void'(exp_q.pop_front());
            model_emitted++;
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("stat_tested_at_done", stat_tested, 64'(model_tested & 64'hFFFF_FFFF));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0][2:0][CW-1:0] zb, rb, b6;
    int n;
    zb = {(9*CW){1'b0}};
    rb = zb; rb[0][2] = 16'hFFFF;
    b6 = zb; b6[0][0] = 16'd1; b6[0][2] = 16'hFFFF;
    resetn = 1'b0; job_valid = 1'b0; frag_ready = 1'b1;
    job_xmin = 16'd0; job_xmax = 16'd0; job_ymin = 16'd0; job_ymax = 16'd0;
    job_bounds = zb; job_color = 16'd0;

    // Model pins.
    check("model_pin_reject", 64'(model_cov(0, 0, rb)), 64'd0);
    check("model_pin_accept", 64'(model_cov(1, 3, b6)), 64'd1);
    check("model_pin_edge", 64'(model_cov(0, 3, b6)), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", job_ready, 64'd1);
    check("rst_frag_valid", frag_valid, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_tested", stat_tested, 64'd0);
    check("rst_emitted", stat_emitted, 64'd0);
    check("rst_frag_x", frag_x, 64'd0);
    check("rst_frag_y", frag_y, 64'd0);
    check("rst_frag_color", frag_color, 64'd0);
    resetn = 1'b1;

    // Full coverage, streaming.
    issue_job(mk_box(16'd2, 16'd4, 16'd1, 16'd2), zb, 16'hABCD);
    check("s1_busy", job_ready, 64'd0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k <= 6) begin
        check("s1_fv", frag_valid, 64'd1);
        check("s1_fx", frag_x, 64'(ex[k-1]));
        check("s1_fy", frag_y, 64'(ey[k-1]));
      end
      check("s1_done", done, 64'(k == 6));
    end
    check("s1_ready", job_ready, 64'd1);
    check("s1_fv_end", frag_valid, 64'd0);
    check("s1_tested", stat_tested, 64'd6);
    check("s1_emitted", stat_emitted, 64'd6);

    // Backpressure after the first fragment.
    issue_job(mk_box(16'd2, 16'd4, 16'd1, 16'd2), zb, 16'h1234);
    @(posedge clk); #1;
    check("s2_fv", frag_valid, 64'd1);
    check("s2_fx", frag_x, 64'd2);
    check("s2_fy", frag_y, 64'd1);
    check("s2_tested", stat_tested, 64'd7);
    frag_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("s2_hold_fv", frag_valid, 64'd1);
      check("s2_hold_fx", frag_x, 64'd2);
      check("s2_hold_fy", frag_y, 64'd1);
      check("s2_hold_tested", stat_tested, 64'd7);
    end
    frag_ready = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      check("s2_fx", frag_x, 64'(ex[k-1]));
      check("s2_fy", frag_y, 64'(ey[k-1]));
      check("s2_tested", stat_tested, 64'(6 + k));
      check("s2_done", done, 64'(k == 6));
    end
    @(posedge clk); #1;
    check("s2_fv_end", frag_valid, 64'd0);
    check("s2_emitted", stat_emitted, 64'd12);

    // Every pixel rejected.
    issue_job(mk_box(16'd0, 16'd1, 16'd0, 16'd1), rb, 16'h00FF);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("s3_fv", frag_valid, 64'd0);
      check("s3_done", done, 64'(k == 4));
      if (k == 4) check("s3_tested", stat_tested, 64'd16);
    end
    check("s3_ready", job_ready, 64'd1);

    // Degenerate box.
    issue_job(mk_box(16'd5, 16'd3, 16'd0, 16'd0), zb, 16'h5555);
    check("s4_done", done, 64'd1);
    check("s4_ready", job_ready, 64'd0);
    check("s4_fv", frag_valid, 64'd0);
    @(posedge clk); #1;
    check("s4_done_low", done, 64'd0);
    check("s4_ready_back", job_ready, 64'd1);
    check("s4_tested", stat_tested, 64'd16);

    // Box at the top of the coordinate range.
    issue_job(mk_box(16'hFFFE, 16'hFFFF, 16'd0, 16'd0), zb, 16'h0F0F);
    @(posedge clk); #1;
    check("s5_fv1", frag_valid, 64'd1);
    check("s5_fx1", frag_x, 64'hFFFE);
    check("s5_fy1", frag_y, 64'd0);
    check("s5_done1", done, 64'd0);
    @(posedge clk); #1;
    check("s5_fx2", frag_x, 64'hFFFF);
    check("s5_done2", done, 64'd1);
    for (int k = 3; k <= 6; k++) begin
      @(posedge clk); #1;
      check("s5_fv_after", frag_valid, 64'd0);
      check("s5_done_after", done, 64'd0);
    end
    check("s5_tested", stat_tested, 64'd18);
    check("s5_emitted", stat_emitted, 64'd14);

    // Reset while pixel 3 is presented.
    issue_job(mk_box(16'd2, 16'd4, 16'd1, 16'd2), zb, 16'h7777);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("s6_fx_pre", frag_x, 64'd3);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("s6_fv", frag_valid, 64'd0);
    check("s6_done", done, 64'd0);
    check("s6_tested", stat_tested, 64'd0);
    check("s6_emitted", stat_emitted, 64'd0);
    check("s6_ready", job_ready, 64'd1);
    resetn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("s6_quiet_fv", frag_valid, 64'd0);
      check("s6_quiet_done", done, 64'd0);
    end
    issue_job(mk_box(16'd0, 16'd2, 16'd3, 16'd3), b6, 16'hBEEF);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("s6_new_done_seen", done, 64'd1);
    @(posedge clk); #1;
    check("s6_new_tested", stat_tested, 64'd3);
    check("s6_new_emitted", stat_emitted, 64'd2);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_pulses", 64'(done_cnt), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
